// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V control FSM: sequences the shared datapath one step per clock,
// decodes IR into selects/strobes, waits on the memory ready handshake and counts
// retired instructions.
module multicycle_controller #(
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Instr,
  input  logic                Zero,
  input  logic                Negative,
  input  logic                MemReady,
  output logic                PCWrite,
  output logic                AdrSrc,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegWrite,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [4:0]          ALUControl,
  output logic [2:0]          ImmSrc,
  output logic                Illegal,
  output logic [3:0]          State,
  output logic [RETIRE_W-1:0] Retired
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9,
    StJal      = 4'd10,
    StJalr     = 4'd11,
    StJalrPc   = 4'd12,
    StLui      = 4'd13
  } state_e;

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpR     = 7'b0110011;
  localparam logic [6:0] OpI     = 7'b0010011;
  localparam logic [6:0] OpB     = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;

  localparam logic [4:0] AluAdd   = 5'b00000;
  localparam logic [4:0] AluSub   = 5'b00001;
  localparam logic [4:0] AluAnd   = 5'b00010;
  localparam logic [4:0] AluOr    = 5'b00011;
  localparam logic [4:0] AluXor   = 5'b00100;
  localparam logic [4:0] AluSlt   = 5'b00101;
  localparam logic [4:0] AluSll   = 5'b00110;
  localparam logic [4:0] AluSrl   = 5'b00111;
  localparam logic [4:0] AluPassB = 5'b01000;

  state_e                state_q, state_d;
  logic [RETIRE_W-1:0]   retired_q;
  logic                  retire;
  logic [4:0]            alu_func;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       unused_instr;

  assign opcode       = Instr[6:0];
  assign funct3       = Instr[14:12];
  assign funct7b5     = Instr[30];
  assign unused_instr = ^{Instr[31], Instr[29:15], Instr[11:7]};

  // ALU operation from funct3; the SUB override for funct7[5] is applied in EXECR only.
  always_comb begin
    alu_func = AluAdd;
    case (funct3)
      3'b111:  alu_func = AluAnd;
      3'b110:  alu_func = AluOr;
      3'b100:  alu_func = AluXor;
      3'b010:  alu_func = AluSlt;
      3'b001:  alu_func = AluSll;
      3'b101:  alu_func = AluSrl;
      default: alu_func = AluAdd;
    endcase
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_d    = state_q;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = AluAdd;
    ImmSrc     = 3'b000;
    Illegal    = 1'b0;
    unique case (state_q)
      StFetch: begin
        MemRead   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
        if (MemReady) state_d = StDecode;
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 3'b010;
        case (opcode)
          OpLoad, OpStore: state_d = StMemAdr;
          OpR:             state_d = StExecR;
          OpI:             state_d = StExecI;
          OpB:             state_d = StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpLui:           state_d = StLui;
          default: begin
            state_d = StFetch;
            Illegal = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (opcode == OpStore) ? 3'b001 : 3'b000;
        state_d = (opcode == OpStore) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        AdrSrc  = 1'b1;
        MemRead = 1'b1;
        if (MemReady) state_d = StMemWb;
      end
      StMemWb: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
        state_d   = StFetch;
      end
      StMemWrite: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (MemReady) state_d = StFetch;
      end
      StExecR: begin
        ALUSrcA    = 2'b10;
        ALUControl = (funct3 == 3'b000 && funct7b5) ? AluSub : alu_func;
        state_d    = StAluWb;
      end
      StExecI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_func;
        state_d    = StAluWb;
      end
      StAluWb: begin
        RegWrite = 1'b1;
        state_d  = StFetch;
      end
      StBranch: begin
        ALUSrcA    = 2'b10;
        ALUControl = AluSub;
        PCWrite    = (funct3 == 3'b000 && Zero) || (funct3 == 3'b100 && Negative);
        state_d    = StFetch;
      end
      StJal: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
        state_d = StAluWb;
      end
      StJalr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = StJalrPc;
      end
      StJalrPc: begin
        PCWrite = 1'b1;
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        state_d = StAluWb;
      end
      StLui: begin
        ALUSrcB    = 2'b01;
        ImmSrc     = 3'b100;
        ALUControl = AluPassB;
        state_d    = StAluWb;
      end
      default: state_d = StFetch;
    endcase
    // Reset must never let a write strobe escape, even while the state is being cleared.
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      MemRead  = 1'b1;
      AdrSrc   = 1'b0;
    end
  end

  // An instruction retires on its final step back to FETCH; the illegal path does not count.
  always_comb begin
    retire = 1'b0;
    if (state_d == StFetch) begin
      retire = (state_q == StMemWb) || (state_q == StMemWrite) ||
               (state_q == StAluWb) || (state_q == StBranch);
    end
  end

  // State register and retired-instruction counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StFetch;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) retired_q <= retired_q + RETIRE_W'(1);
    end
  end

  assign State   = state_q;
  assign Retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction walks with literal expectations,
// then randomized instructions/handshakes checked every cycle against a behavioural model.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Instr = '0;
  logic        Zero = 1'b0;
  logic        Negative = 1'b0;
  logic        MemReady = 1'b0;
  logic        PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic [4:0]  ALUControl;
  logic [2:0]  ImmSrc;
  logic [3:0]  State;
  logic [31:0] Retired;

  multicycle_controller #(.RETIRE_W(32)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .Zero(Zero), .Negative(Negative),
    .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .Illegal(Illegal), .State(State), .Retired(Retired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic pcw, adr, mrd, mwr, irw, rw;
    logic [1:0] rs, sa, sb;
    logic [4:0] alu;
    logic [2:0] imm;
    logic ill;
  } outs_t;

  localparam int SFETCH = 0, SDECODE = 1, SMEMADR = 2, SMEMREAD = 3, SMEMWB = 4;
  localparam int SMEMWRITE = 5, SEXECR = 6, SEXECI = 7, SALUWB = 8, SBRANCH = 9;
  localparam int SJAL = 10, SJALR = 11, SJALRPC = 12, SLUI = 13;
  // ALU code indexed by funct3 (ADD,SLL,SLT,ADD,XOR,SRL,OR,AND)
  localparam logic [4:0] ALU_TAB [8] = '{5'd0, 5'd6, 5'd5, 5'd0, 5'd4, 5'd7, 5'd3, 5'd2};

  function automatic int model_next(int st, logic [6:0] op, logic mr);
    case (st)
      SFETCH:    return mr ? SDECODE : SFETCH;
      SDECODE: begin
        if (op == 7'b0000011 || op == 7'b0100011) return SMEMADR;
        if (op == 7'b0110011) return SEXECR;
        if (op == 7'b0010011) return SEXECI;
        if (op == 7'b1100011) return SBRANCH;
        if (op == 7'b1101111) return SJAL;
        if (op == 7'b1100111) return SJALR;
        if (op == 7'b0110111) return SLUI;
        return SFETCH;
      end
      SMEMADR:   return (op == 7'b0100011) ? SMEMWRITE : SMEMREAD;
      SMEMREAD:  return mr ? SMEMWB : SMEMREAD;
      SMEMWRITE: return mr ? SFETCH : SMEMWRITE;
      SEXECR, SEXECI, SJAL, SJALRPC, SLUI: return SALUWB;
      SJALR:     return SJALRPC;
      default:   return SFETCH;
    endcase
  endfunction

  function automatic outs_t model_out(int st, logic [31:0] ins, logic z, logic n, logic mr,
                                      logic rst);
    outs_t o;
    logic [2:0] f3;
    f3 = ins[14:12];
    o = '0;
    case (st)
      SFETCH:    begin o.mrd = 1; o.sb = 2; o.rs = 2; o.irw = mr; o.pcw = mr; end
      SDECODE:   begin o.sa = 1; o.sb = 1; o.imm = 2;
                   o.ill = (model_next(SDECODE, ins[6:0], mr) == SFETCH); end
      SMEMADR:   begin o.sa = 2; o.sb = 1; o.imm = (ins[6:0] == 7'b0100011) ? 3'd1 : 3'd0; end
      SMEMREAD:  begin o.adr = 1; o.mrd = 1; end
      SMEMWB:    begin o.rs = 1; o.rw = 1; end
      SMEMWRITE: begin o.adr = 1; o.mwr = 1; end
      SEXECR:    begin o.sa = 2; o.alu = (f3 == 0 && ins[30]) ? 5'd1 : ALU_TAB[f3]; end
      SEXECI:    begin o.sa = 2; o.sb = 1; o.alu = ALU_TAB[f3]; end
      SALUWB:    o.rw = 1;
      SBRANCH:   begin o.sa = 2; o.alu = 1; o.pcw = (f3 == 0 && z) || (f3 == 4 && n); end
      SJAL:      begin o.sa = 1; o.sb = 2; o.pcw = 1; end
      SJALR:     begin o.sa = 2; o.sb = 1; end
      SJALRPC:   begin o.sa = 1; o.sb = 2; o.pcw = 1; end
      SLUI:      begin o.sb = 1; o.imm = 4; o.alu = 8; end
      default:   ;
    endcase
    if (rst) begin
      o.pcw = 0; o.irw = 0; o.rw = 0; o.mwr = 0; o.mrd = 1; o.adr = 0;
    end
    return o;
  endfunction

  int          m_state = 0;
  int          m_next = 0;
  logic [31:0] m_ret = '0;
  logic [31:0] m_ret_next = '0;
  outs_t       act_o, exp_o;

  assign act_o = '{pcw: PCWrite, adr: AdrSrc, mrd: MemRead, mwr: MemWrite, irw: IRWrite,
                   rw: RegWrite, rs: ResultSrc, sa: ALUSrcA, sb: ALUSrcB, alu: ALUControl,
                   imm: ImmSrc, ill: Illegal};

  // Compare every cycle mid-period, then advance the model's view of the next state.
  always @(negedge clk) begin
    exp_o = model_out(m_state, Instr, Zero, Negative, MemReady, reset);
    chk("outputs", 64'(act_o), 64'(exp_o));
    chk("state", 64'(State), 64'(m_state));
    chk("retired", 64'(Retired), 64'(m_ret));
    if (reset) begin
      m_next = SFETCH;
      m_ret_next = '0;
    end else begin
      m_next = model_next(m_state, Instr[6:0], MemReady);
      m_ret_next = m_ret;
      if (m_next == SFETCH && (m_state == SMEMWB || m_state == SMEMWRITE ||
                               m_state == SALUWB || m_state == SBRANCH))
        m_ret_next = m_ret + 1;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state <= SFETCH;
      m_ret   <= '0;
    end else begin
      m_state <= m_next;
      m_ret   <= m_ret_next;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic [31:0] ins, input logic mr);
    @(posedge clk);
    #1;
    Instr = ins;
    MemReady = mr;
    @(negedge clk);
  endtask

  task automatic run_seq(input string nm, input logic [31:0] ins, input int seq[$]);
    for (int k = 0; k < seq.size(); k++) begin
      step(ins, 1'b1);
      chk({nm, "_state"}, 64'(State), 64'(seq[k]));
    end
  endtask

  // Parks one cycle in FETCH with no ready, where the retire count is settled.
  task automatic idle_fetch(input string nm, input int exp_ret);
    step(Instr, 1'b0);
    chk({nm, "_fetch"}, 64'(State), 64'd0);
    chk({nm, "_retired"}, 64'(Retired), 64'(exp_ret));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [8];
    logic [31:0] r;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    r = $urandom;
    if ($urandom_range(0, 7) == 0) r[6:0] = 7'($urandom);
    else r[6:0] = ops[$urandom_range(0, 7)];
    return r;
  endfunction

  initial begin
    #2 reset = 1'b1;
    MemReady = 1'b1;
    @(negedge clk);
    chk("rst_state", 64'(State), 64'd0);
    chk("rst_retired", 64'(Retired), 64'd0);
    chk("rst_irwrite", 64'(IRWrite), 64'd0);
    chk("rst_pcwrite", 64'(PCWrite), 64'd0);
    chk("rst_memread", 64'(MemRead), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    MemReady = 1'b0;

    // addi
    run_seq("addi", 32'h03200093, '{0, 1, 7});
    chk("addi_alu", 64'(ALUControl), 64'd0);
    chk("addi_srcb", 64'(ALUSrcB), 64'd1);
    chk("addi_rw_exec", 64'(RegWrite), 64'd0);
    run_seq("addi", 32'h03200093, '{8});
    chk("addi_rw_wb", 64'(RegWrite), 64'd1);
    idle_fetch("addi", 1);

    // lw with two wait cycles in MEMREAD
    run_seq("lw", 32'hffc02103, '{0, 1, 2});
    for (int k = 0; k < 3; k++) begin
      step(32'hffc02103, (k == 2));
      chk("lw_wait_state", 64'(State), 64'd3);
      chk("lw_memread", 64'({MemRead, AdrSrc}), 64'b11);
    end
    step(32'hffc02103, 1'b1);
    chk("lw_wb_state", 64'(State), 64'd4);
    chk("lw_wb_ctrl", 64'({ResultSrc, RegWrite}), 64'b011);
    idle_fetch("lw", 2);

    // beq taken and not taken
    Zero = 1'b1;
    run_seq("beq_t", 32'h00000063, '{0, 1, 9});
    chk("beq_taken_pcw", 64'(PCWrite), 64'd1);
    idle_fetch("beq_t", 3);
    Zero = 1'b0;
    run_seq("beq_n", 32'h00000063, '{0, 1, 9});
    chk("beq_not_pcw", 64'(PCWrite), 64'd0);
    idle_fetch("beq_n", 4);

    // sub
    run_seq("sub", 32'h402081b3, '{0, 1, 6});
    chk("sub_alu", 64'(ALUControl), 64'd1);
    run_seq("sub", 32'h402081b3, '{8});
    idle_fetch("sub", 5);

    // jal
    run_seq("jal", 32'h000000ef, '{0, 1, 10});
    chk("jal_pcw", 64'(PCWrite), 64'd1);
    run_seq("jal", 32'h000000ef, '{8});
    idle_fetch("jal", 6);

    // jalr
    run_seq("jalr", 32'h000100e7, '{0, 1, 11, 12, 8});
    idle_fetch("jalr", 7);

    // lui
    run_seq("lui", 32'h00001037, '{0, 1, 13});
    chk("lui_alu", 64'(ALUControl), 64'd8);
    chk("lui_imm", 64'(ImmSrc), 64'd4);
    run_seq("lui", 32'h00001037, '{8});
    idle_fetch("lui", 8);

    // illegal opcode
    run_seq("ill", 32'hffffffff, '{0, 1});
    chk("ill_pulse", 64'(Illegal), 64'd1);
    idle_fetch("ill", 8);

    // sw stalled in MEMWRITE, then asynchronous reset mid-wait
    run_seq("sw", 32'hfe302e23, '{0, 1, 2});
    for (int k = 0; k < 2; k++) begin
      step(32'hfe302e23, 1'b0);
      chk("sw_state", 64'(State), 64'd5);
      chk("sw_memwrite", 64'(MemWrite), 64'd1);
    end
    #2 reset = 1'b1;
    #1;
    chk("sw_rst_memwrite", 64'(MemWrite), 64'd0);
    chk("sw_rst_state", 64'(State), 64'd0);
    chk("sw_rst_retired", 64'(Retired), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // randomized traffic, model compares every cycle
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) Instr = rand_instr();
      MemReady = ($urandom_range(0, 2) != 0);
      Zero     = 1'($urandom);
      Negative = 1'($urandom);
      reset    = ($urandom_range(0, 199) == 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
